wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage and register file of the single-cycle CPU; sits directly downstream of the destination-select logic.
- That logic supplies the final write-register number `wn` (forced to 31 on `jal`) and a data-select `dsel`.
- This block selects the write data: link address when `dsel`=1, else the ALU/memory result. It commits the selected data on the clock edge.
- It also provides two combinational read ports for decode and one debug read port for the FPGA display.

Parameters:
- DW, 32, data width of each register
- AW, 5, register-number width; depth is 2**AW
- BYPASS, 0, 1 = a read of the register being written this cycle returns the write data; 0 = returns the stored value

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- we  input  1  register write enable from the control unit
- dsel  input  1  write-data select: 1 = link_addr, 0 = res
- wn  input  AW  write register number
- res  input  DW  ALU/memory result
- link_addr  input  DW  return address for jal (PC+4 as computed by the fetch stage)
- rna  input  AW  read port A register number
- rnb  input  AW  read port B register number
- qa  output  DW  read port A data
- qb  output  DW  read port B data
- dbg_rn  input  AW  debug read register number
- dbg_q  output  DW  debug read data (never bypassed)
- wr_cnt  output  16  count of committed writes, for bring-up/debug

Behaviour:
- Reset: while `rst`=1, asynchronously clear all registers 1..2**AW-1 and `wr_cnt` to 0. `qa`, `qb` and `dbg_q` therefore read 0 during and after reset until written. Reset mid-cycle aborts any pending write; nothing commits on an edge where `rst`=1.
- Write data: `wd` = `dsel` ? `link_addr` : `res`. Purely combinational, zero latency.
- Commit: on a rising `clk` edge with `rst`=0, `we`=1 and `wn`!=0, register[`wn`] <= `wd` and `wr_cnt` <= `wr_cnt`+1.
  - `wr_cnt` wraps from 0xFFFF to 0x0000 with no saturation.
  - When `we`=0, or `wn`=0, nothing changes and `wr_cnt` holds.
- Register 0: hardwired zero. It is not stored; any read of register 0 returns 0, including when bypassed and when `wn`=0 with `we`=1.
- Reads: `qa`/`qb`/`dbg_q` are combinational from the register array, with no clock latency. A write is visible on the read ports in the cycle after the commit edge.
- Bypass (BYPASS=1): if `we`=1, `wn`!=0 and `rna`==`wn`, then `qa`=`wd`; same rule for `qb` with `rnb`. `dbg_q` is never bypassed.
- Simultaneous events:
  - `rna`==`rnb`==`wn`: both ports see identical data under either BYPASS setting.
  - `dsel`=1 with `we`=0: no write, even though the link path is selected.
  - Changing `wn`/`wd` between edges has no effect; only values at the edge commit.
- `jal` convention: upstream forces `wn`=31 and `dsel`=1. This block does not special-case 31; it is an ordinary register.
- No X propagation: out-of-range indices cannot occur, since depth is exactly 2**AW.

Decomposition:
- Shared package `cpu_pkg`, holding:
  - DW and AW defaults
  - REG_ZERO = 0
  - REG_RA = 31 (link register, used by the dst-select logic and by benches)
  - DSEL_RES = 0, DSEL_LINK = 1
- One natural sub-module: `wb_mux`, the parameterised 2:1 write-data selector (`dsel`, `res`, `link_addr` -> `wd`), instantiated once. The array, counter and read logic stay in `wb_regfile`.

Test Plan:
- Reset then read: write r5=0x1234, assert `rst` asynchronously between edges -> `qa` for `rna`=5 drops to 0 immediately; `wr_cnt`=0.
- ALU write: `we`=1, `dsel`=0, `wn`=8, `res`=0xDEADBEEF, one edge -> `qa`(`rna`=8)=0xDEADBEEF next cycle; `wr_cnt`=1.
- jal link write: `we`=1, `dsel`=1, `wn`=31, `link_addr`=0x00400024, `res`=0xFFFFFFFF -> r31=0x00400024; `dbg_q`(`dbg_rn`=31)=0x00400024.
- r0 protection: `we`=1, `wn`=0, `res`=0xAAAA5555 -> `qa`(`rna`=0)=0 before and after the edge; `wr_cnt` unchanged.
- Same-cycle read/write: r3=0x11, then `we`=1, `wn`=3, `res`=0x22 with `rna`=`rnb`=3:
  - BYPASS=0 -> `qa`=`qb`=0x11 before the edge, 0x22 after.
  - BYPASS=1 -> `qa`=`qb`=0x22 before the edge.
  - `dbg_q`=0x11 before the edge in both cases.
- Counter wrap: perform 65536 writes to r1 -> `wr_cnt` returns to 0x0000; r1 holds the last written value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths, well-known register numbers and
// write-data select encodings.
package cpu_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic DSEL_RES  = 1'b0;
  localparam logic DSEL_LINK = 1'b1;
endpackage

// File: rtl/wb_mux.sv
// Write-back data selector: link address for jal, else ALU/memory result.
module wb_mux
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          dsel,
  input  logic [DW-1:0] res,
  input  logic [DW-1:0] link_addr,
  output logic [DW-1:0] wd
);
  assign wd = (dsel == DSEL_LINK) ? link_addr : res;
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and register file: r0 hardwired to zero, two decode read
// ports with optional write bypass, one unbypassed debug port, write counter.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int BYPASS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          dsel,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] res,
  input  logic [DW-1:0] link_addr,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic [AW-1:0] dbg_rn,
  output logic [DW-1:0] dbg_q,
  output logic [15:0]   wr_cnt
);
  localparam int DEPTH = 1 << AW;

  // r0 is never stored; reads of it are forced to zero below.
  logic [DW-1:0] regs_q [1:DEPTH-1];
  logic [DW-1:0] regs_d [1:DEPTH-1];
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic [DW-1:0] wd;
  logic          commit;

  wb_mux #(.DW(DW)) u_wb_mux (
    .dsel      (dsel),
    .res       (res),
    .link_addr (link_addr),
    .wd        (wd)
  );

  assign commit = we && (wn != '0);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      regs_d[wn] = wd;
      wr_cnt_d   = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    qa    = (rna == '0)    ? '0 : regs_q[rna];
    qb    = (rnb == '0)    ? '0 : regs_q[rnb];
    dbg_q = (dbg_rn == '0) ? '0 : regs_q[dbg_rn];
    // commit already excludes wn==0, so r0 stays zero under bypass.
    if (BYPASS != 0 && commit && rna == wn) qa = wd;
    if (BYPASS != 0 && commit && rnb == wn) qb = wd;
  end

  assign wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: BYPASS=0 and BYPASS=1 instances side by side, checked
// every cycle against an array model plus directed literal expectations.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, dsel = 1'b0;
  logic [4:0]  wn = '0, rna = '0, rnb = '0, dbg_rn = '0;
  logic [31:0] res = '0, link_addr = '0;
  logic [31:0] qa0, qb0, dq0, qa1, qb1, dq1;
  logic [15:0] cnt0, cnt1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DW(32), .AW(5), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .dsel(dsel), .wn(wn), .res(res),
    .link_addr(link_addr), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
    .dbg_rn(dbg_rn), .dbg_q(dq0), .wr_cnt(cnt0));

  wb_regfile #(.DW(32), .AW(5), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .dsel(dsel), .wn(wn), .res(res),
    .link_addr(link_addr), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
    .dbg_rn(dbg_rn), .dbg_q(dq1), .wr_cnt(cnt1));

  // Architectural model: 32 registers, r0 pinned to zero, plain counter.
  logic [31:0] mreg [32];
  int unsigned mcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      mcnt = 0;
    end else if (we && wn != REG_ZERO) begin
      mreg[wn] = dsel ? link_addr : res;
      mcnt = (mcnt + 1) % 65536;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] rn, input bit byp);
    if (rn == REG_ZERO) return 32'h0;
    if (byp && we && wn != REG_ZERO && rn == wn) return dsel ? link_addr : res;
    return mreg[rn];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("qa0",  qa0,  exp_rd(rna, 1'b0));
    chk("qb0",  qb0,  exp_rd(rnb, 1'b0));
    chk("dbg0", dq0,  exp_rd(dbg_rn, 1'b0));
    chk("qa1",  qa1,  exp_rd(rna, 1'b1));
    chk("qb1",  qb1,  exp_rd(rnb, 1'b1));
    chk("dbg1", dq1,  exp_rd(dbg_rn, 1'b0));
    chk("cnt0", {16'h0, cnt0}, mcnt);
    chk("cnt1", {16'h0, cnt1}, mcnt);
  end

  // Drive a single write, commit it on the next edge, then deassert we.
  task automatic do_write(input logic [4:0] r, input logic ds,
                          input logic [31:0] rv, input logic [31:0] lv);
    @(posedge clk); #2;
    we = 1'b1; wn = r; dsel = ds; res = rv; link_addr = lv;
    @(posedge clk); #2;
    we = 1'b0; dsel = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("lit_reset_qa", qa0, 32'h0);
    chk("lit_reset_cnt", {16'h0, cnt0}, 32'h0);

    // Asynchronous reset between edges wipes r5 at once.
    do_write(5'd5, DSEL_RES, 32'h1234, 32'h0);
    rna = 5'd5; #1;
    chk("lit_r5", qa0, 32'h1234);
    rst = 1'b1; #1;
    chk("lit_async_rst_qa0", qa0, 32'h0);
    chk("lit_async_rst_qa1", qa1, 32'h0);
    chk("lit_async_rst_cnt", {16'h0, cnt0}, 32'h0);
    @(posedge clk); #2 rst = 1'b0;

    // ALU write to r8.
    do_write(5'd8, DSEL_RES, 32'hDEADBEEF, 32'h0);
    rna = 5'd8; #1;
    chk("lit_alu_qa", qa0, 32'hDEADBEEF);
    chk("lit_alu_cnt", {16'h0, cnt1}, 32'd1);

    // jal link write to r31.
    do_write(REG_RA, DSEL_LINK, 32'hFFFFFFFF, 32'h00400024);
    dbg_rn = REG_RA; #1;
    chk("lit_jal_dbg0", dq0, 32'h00400024);
    chk("lit_jal_dbg1", dq1, 32'h00400024);

    // r0 protection: write attempt, bypass must not leak the data.
    @(posedge clk); #2;
    rna = REG_ZERO; rnb = REG_ZERO;
    we = 1'b1; wn = REG_ZERO; res = 32'hAAAA5555; #1;
    chk("lit_r0_pre_qa1", qa1, 32'h0);
    @(posedge clk); #2 we = 1'b0; #1;
    chk("lit_r0_post_qa0", qa0, 32'h0);
    chk("lit_r0_cnt", {16'h0, cnt0}, 32'd2);

    // Link selected but no write enable: nothing commits.
    @(posedge clk); #2;
    we = 1'b0; dsel = 1'b1; wn = 5'd7; link_addr = 32'h5555AAAA; rna = 5'd7;
    @(posedge clk); #2; #1;
    chk("lit_nowe_qa", qa0, 32'h0);
    chk("lit_nowe_cnt", {16'h0, cnt0}, 32'd2);
    dsel = 1'b0;

    // Same-cycle read/write of r3 on both ports.
    do_write(5'd3, DSEL_RES, 32'h11, 32'h0);
    rna = 5'd3; rnb = 5'd3; dbg_rn = 5'd3;
    we = 1'b1; wn = 5'd3; res = 32'h22; #1;
    chk("lit_same_qa0", qa0, 32'h11);
    chk("lit_same_qb0", qb0, 32'h11);
    chk("lit_same_qa1", qa1, 32'h22);
    chk("lit_same_qb1", qb1, 32'h22);
    chk("lit_same_dbg1", dq1, 32'h11);
    @(posedge clk); #2 we = 1'b0; #1;
    chk("lit_same_post_qa0", qa0, 32'h22);
    chk("lit_same_post_qb0", qb0, 32'h22);

    // Counter wrap: 65536 back-to-back writes to r1 from a clean count.
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    rna = 5'd1; rnb = 5'd2; dbg_rn = 5'd1;
    we = 1'b1; wn = 5'd1; dsel = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      res = i;
      @(posedge clk); #2;
    end
    we = 1'b0; #1;
    chk("lit_wrap_cnt0", {16'h0, cnt0}, 32'h0);
    chk("lit_wrap_cnt1", {16'h0, cnt1}, 32'h0);
    chk("lit_wrap_r1", qa0, 32'h0000FFFF);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
